// File: rtl/data_mem_stage.sv
// Data-memory pipeline stage: byte-addressable store/load with a one-cycle load stall.
// Optional misalignment detection is enabled by defining DATA_MEM_MISALIGN_CHECK_EN.
module data_mem_stage #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  funct3,
  input  logic        ResultSrc,
  output logic [31:0] Result,
  output logic        Stall,
  output logic        Misalign
);

  localparam int unsigned WORD_IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned NUM_WORDS  = 1 << WORD_IDX_W;

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] LOAD_WAIT = 1'b1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [0:0]            state, state_nxt;
  logic [31:0]           mem [NUM_WORDS];
  logic [31:0]           load_data;
  logic [WORD_IDX_W-1:0] widx;
  logic [1:0]            byte_off;
  logic                  is_store, is_load, size_h, size_w;
  logic                  misalign_c;
  logic                  store_en, load_start, load_zero;
  logic [3:0]            byte_en;
  logic [31:0]           store_word;
  logic [31:0]           rd_word, lane_w, load_fmt;
  logic                  unused_addr_bits;

  // Upper address bits wrap the memory and are deliberately ignored
  assign unused_addr_bits = ^ALUResult[31:ADDR_WIDTH];

  assign widx     = ALUResult[ADDR_WIDTH-1:2];
  assign is_store = MemWrite;
  assign is_load  = MemRead & ~MemWrite;
  assign size_h   = (funct3 == F3_H) | (is_load & (funct3 == F3_HU));
  assign size_w   = (funct3 == F3_W);

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  assign byte_off   = ALUResult[1:0];
  assign misalign_c = (state == IDLE) & ~rst & (is_store | is_load) &
                      ((size_h & ALUResult[0]) | (size_w & (ALUResult[1:0] != 2'b00)));
`else
  // Without the checker, accesses snap to their natural alignment
  assign byte_off   = size_w ? 2'b00 : (size_h ? {ALUResult[1], 1'b0} : ALUResult[1:0]);
  assign misalign_c = 1'b0;
`endif

  assign Misalign = misalign_c;

  // Next-state and control decode
  always_comb begin
    state_nxt  = state;
    store_en   = 1'b0;
    load_start = 1'b0;
    load_zero  = 1'b0;
    Stall      = 1'b0;
    if (state == IDLE) begin
      if (is_store) begin
        store_en = ~misalign_c;
      end else if (is_load) begin
        if (misalign_c) begin
          load_zero = 1'b1;
        end else begin
          load_start = 1'b1;
          Stall      = ~rst;
          state_nxt  = LOAD_WAIT;
        end
      end
    end else begin
      state_nxt = IDLE;
    end
  end

  // Store lane selection and data replication
  always_comb begin
    byte_en    = 4'b0000;
    store_word = 32'h0;
    case (funct3)
      F3_B: begin
        byte_en    = 4'(4'b0001 << byte_off);
        store_word = {4{WriteData[7:0]}};
      end
      F3_H: begin
        byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
        store_word = {2{WriteData[15:0]}};
      end
      F3_W: begin
        byte_en    = 4'b1111;
        store_word = WriteData;
      end
      default: begin
        byte_en    = 4'b0000;
        store_word = 32'h0;
      end
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    rd_word  = mem[widx];
    lane_w   = rd_word >> {byte_off, 3'b000};
    load_fmt = 32'h0;
    case (funct3)
      F3_B:    load_fmt = {{24{lane_w[7]}}, lane_w[7:0]};
      F3_H:    load_fmt = {{16{lane_w[15]}}, lane_w[15:0]};
      F3_W:    load_fmt = rd_word;
      F3_BU:   load_fmt = {24'h0, lane_w[7:0]};
      F3_HU:   load_fmt = {16'h0, lane_w[15:0]};
      default: load_fmt = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      load_data <= 32'h0;
    end else begin
      state <= state_nxt;
      if (load_start) begin
        load_data <= load_fmt;
      end else if (load_zero) begin
        load_data <= 32'h0;
      end
    end
  end

  // Memory array is intentionally not reset
  always_ff @(posedge clk) begin
    if (store_en && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[widx][b*8 +: 8] <= store_word[b*8 +: 8];
        end
      end
    end
  end

  assign Result = ResultSrc ? load_data : ALUResult;

endmodule

// File: doc/data_mem_stage.md
DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, byte-address bits decoded; memory is 2^ADDR_WIDTH bytes stored as 2^(ADDR_WIDTH-2) little-endian 32-bit words.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port ALUResult  input  32  byte address for loads/stores; also the non-memory result.
REQ-005 Port WriteData  input  32  store data (register RD2); low byte/half used for SB/SH.
REQ-006 Port MemWrite  input  1  store request.
REQ-007 Port MemRead  input  1  load request.
REQ-008 Port funct3  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only.
REQ-009 Port ResultSrc  input  1  writeback select: 0 ALUResult, 1 load data.
REQ-010 Port Result  output  32  writeback value to register file WD3.
REQ-011 Port Stall  output  1  upstream must hold all inputs while high.
REQ-012 Port Misalign  output  1  misaligned-access indication.

Function
REQ-013 Address decode SHALL use ALUResult[ADDR_WIDTH-1:0]; upper bits ignored (wrap modulo 2^ADDR_WIDTH).
REQ-014 FSM SHALL have two states, IDLE and LOAD_WAIT; reset state IDLE.
REQ-015 Store: in IDLE with MemWrite=1, bytes selected by funct3/address SHALL commit at that rising edge; no stall; other bytes of the word unchanged.
REQ-016 MemWrite=1 and MemRead=1 together SHALL be treated as a store; MemRead ignored.
REQ-017 Load: in IDLE with MemRead=1 (MemWrite=0), Stall SHALL be 1 combinationally that cycle; the word is read and formatted into a load-data register at the edge; state goes to LOAD_WAIT.
REQ-018 In LOAD_WAIT, Stall SHALL be 0, inputs SHALL be ignored (no new load/store started), state returns to IDLE next edge; load latency is exactly 2 cycles.
REQ-019 Load formatting: B/H sign-extend, BU/HU zero-extend, W unmodified; byte lane chosen by address[1:0].
REQ-020 Unsupported funct3 on a load SHALL yield load data 0; on a store SHALL write nothing.
REQ-021 Result SHALL be combinational: ResultSrc=1 -> load-data register, ResultSrc=0 -> ALUResult.
REQ-022 Load-data register SHALL hold its value until the next load completes.
REQ-023 Store to the address being loaded in the following cycle SHALL be visible to that load (write-then-read ordering).

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE and load-data register 0, aborting any load mid-operation; Stall=0 and Misalign=0 while rst is held.
REQ-025 Memory array contents SHALL NOT be reset; a store coincident with rst=1 SHALL be suppressed.

Configuration
REQ-026 Macro DATA_MEM_MISALIGN_CHECK_EN defined: H/HU/SH with address[0]=1 or W/SW with address[1:0]!=0 SHALL set Misalign=1 combinationally in IDLE, suppress the store, and on a load skip LOAD_WAIT (Stall=0) and write 0 to the load-data register.
REQ-027 Macro not defined: Misalign SHALL be tied 0 and address low bits SHALL be forced to natural alignment (bit 0 cleared for H, bits 1:0 cleared for W).

Verification
REQ-028 SW 0xDEADBEEF @0x004, then LW @0x004, ResultSrc=1 -> Stall high 1 cycle, Result=0xDEADBEEF in LOAD_WAIT cycle.
REQ-029 SB 0x80 @0x007 over word 0 at 0x004, LB @0x007 -> 0xFFFFFF80; LBU -> 0x00000080; LW @0x004 -> 0x80000000.
REQ-030 SH 0x1234 @0x00A, LHU @0x00A -> 0x00001234; address 0x0000100A (ADDR_WIDTH=12) aliases to same location.
REQ-031 rst asserted in LOAD_WAIT -> next cycle state IDLE, Result (ResultSrc=1)=0, Stall=0.
REQ-032 With DATA_MEM_MISALIGN_CHECK_EN: SW @0x006 -> Misalign=1, memory unchanged; LW @0x006 -> Stall=0, Result=0. Without: SW @0x006 writes word at 0x004.
REQ-033 MemWrite=MemRead=1 SW 0x55 @0x010 -> stored, Stall=0; ResultSrc=0 -> Result=0x00000010.
